pulse_meter: RTL and testbench
==============================

PULSE_METER -- requirements
Module: pulse_meter

Interface
REQ-001 clk  input  1  system clock; all state updates on rising edge.
REQ-002 rst  input  1  reset, asynchronous, active-low.
REQ-003 en  input  1  measurement enable; low forces IDLE.
REQ-004 pulse_in  input  1  asynchronous pulse train whose rising-edge interval is measured.
REQ-005 timeout  input  32  max interval in clk cycles; 0 disables timeout; sampled every cycle.
REQ-006 meas_ack  input  1  consumer acknowledge for the current measurement.
REQ-007 period_out  output  32  last measured interval in clk cycles.
REQ-008 meas_valid  output  1  period_out holds an unacknowledged measurement.
REQ-009 overrun  output  1  sticky; a measurement was overwritten before acknowledgement.
REQ-010 tmo  output  1  one-cycle pulse on interval timeout.
REQ-011 count  output  10  number of completed measurements since enable.

Function
REQ-012 pulse_in SHALL pass a 2-FF synchronizer plus a history FF; rise event = sync2 high and history low.
REQ-013 Rise-event latency SHALL be: pin high before edge k -> rise event acted on at edge k+2.
REQ-014 FSM states SHALL be IDLE, ARM, MEASURE; the state encoding is internal.
REQ-015 IDLE: en low forces IDLE from any state; clears cnt, meas_valid, overrun, tmo, count; period_out holds.
REQ-016 IDLE -> ARM on the first edge with en high; rise events during IDLE are ignored.
REQ-017 ARM: on a rise event, internal 32-bit cnt <= 0 and state -> MEASURE; no measurement produced.
REQ-018 MEASURE, no rise event: cnt SHALL increment by 1, saturating at 0xFFFFFFFF (no wrap).
REQ-019 MEASURE, rise event: period_out <= cnt+1 (saturated at 0xFFFFFFFF), cnt <= 0, meas_valid <= 1, count <= count+1, remain MEASURE.
REQ-020 Rise events at edges N and N+P SHALL yield period_out = P.
REQ-021 count SHALL wrap 1023 -> 0 without any flag.
REQ-022 Timeout: in MEASURE with timeout != 0, no rise event, and cnt+1 == timeout: tmo = 1 for one cycle, cnt <= 0, state -> ARM; no measurement; count unchanged.
REQ-023 A rise event in the same cycle as the timeout condition SHALL win: capture, no tmo.
REQ-024 meas_ack with meas_valid high and no capture SHALL clear meas_valid next edge; ack with meas_valid low is ignored.
REQ-025 Capture with meas_valid high and meas_ack low SHALL overwrite period_out and set overrun.
REQ-026 Capture and meas_ack in the same cycle SHALL leave meas_valid = 1 with new data; overrun unchanged.
REQ-027 overrun SHALL stay set until en low or reset.
REQ-028 A change of timeout mid-interval SHALL take effect on the next cycle's compare.

Reset
REQ-029 rst low SHALL asynchronously force IDLE, clear synchronizer/history FFs, cnt, period_out, meas_valid, overrun, tmo, count to 0.
REQ-030 Reset mid-measurement SHALL discard the partial interval; after release the first rise event only re-arms.
REQ-031 Reset release SHALL be synchronous with clk (deasserted externally on a clk edge).

Verification
REQ-032 en=1, timeout=0, rising edges 100 clk apart, 4 edges -> 3 captures, period_out=100 each, count=3.
REQ-033 timeout=50, second edge 80 cycles after first -> tmo pulse 50 cycles after first rise event, state ARM, count=0; next edge only re-arms.
REQ-034 period 20, meas_ack never asserted -> after 2nd capture overrun=1, period_out=20, meas_valid=1; en low clears overrun and count.
REQ-035 meas_ack asserted on exact capture cycle -> meas_valid stays 1, overrun stays 0; ack next cycle -> meas_valid=0.
REQ-036 1025 captures at period 4 -> count wraps to 1; rst low mid-interval -> all outputs 0 immediately.
REQ-037 timeout=0, no edge for 2^32+5 cycles (forced cnt preload) then edge -> period_out=0xFFFFFFFF.

Source files
------------

// File: rtl/pulse_meter.sv
// ----------------------------------------------------------------------------
// pulse_meter
//
// Measures the interval, in clk cycles, between successive rising edges of an
// asynchronous pulse train.
//
// The pulse input is brought into the clk domain through two flops. A third
// "history" flop holds the previous synchronized value. A rise event is
// acted on two edges after the pin is first seen high.
//
// The first rise event after enable only arms the meter. Each later rise
// event captures the elapsed interval into period_out. An optional timeout
// abandons an interval that runs too long and returns the meter to ARM.
//
// Ports
//   clk        in   system clock, rising edge
//   rst        in   asynchronous reset, active-low
//   en         in   measurement enable; low returns to IDLE and clears status
//   pulse_in   in   asynchronous pulse train
//   timeout    in   [31:0] max interval in cycles, 0 disables, read each cycle
//   meas_ack   in   consumer acknowledge of the current measurement
//   period_out out  [31:0] last captured interval
//   meas_valid out  period_out holds an unacknowledged measurement
//   overrun    out  sticky: a measurement was overwritten before it was acked
//   tmo        out  one-cycle pulse when an interval times out
//   count      out  [9:0] captures since enable, wraps silently
// ----------------------------------------------------------------------------
module pulse_meter (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        pulse_in,
  input  logic [31:0] timeout,
  input  logic        meas_ack,
  output logic [31:0] period_out,
  output logic        meas_valid,
  output logic        overrun,
  output logic        tmo,
  output logic [9:0]  count
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    MEASURE = 2'd2
  } state_t;

  state_t      state_q, state_d;

  logic        sync1_q, sync1_d;
  logic        sync2_q, sync2_d;
  logic        hist_q,  hist_d;

  logic [31:0] cnt_q, cnt_d;
  logic [31:0] period_q, period_d;
  logic        meas_valid_q, meas_valid_d;
  logic        overrun_q, overrun_d;
  logic        tmo_q, tmo_d;
  logic [9:0]  count_q, count_d;

  logic        rise;
  logic        timeout_hit;
  logic [31:0] cnt_sat_inc;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    if (v == 32'hFFFF_FFFF) begin
      return v;
    end
    return v + 32'd1;
  endfunction

  // A rise is a synchronized high that the history flop has not yet seen.
  assign rise        = sync2_q & ~hist_q;
  assign cnt_sat_inc = sat_inc(cnt_q);

  // The compare uses a 33-bit sum so that cnt = all-ones never matches a
  // small timeout through wraparound.
  assign timeout_hit = (timeout != 32'd0) &&
                       (({1'b0, cnt_q} + 33'd1) == {1'b0, timeout});

  always_comb begin
    sync1_d      = pulse_in;
    sync2_d      = sync1_q;
    hist_d       = sync2_q;

    state_d      = state_q;
    cnt_d        = cnt_q;
    period_d     = period_q;
    meas_valid_d = meas_valid_q;
    overrun_d    = overrun_q;
    tmo_d        = 1'b0;
    count_d      = count_q;

    if (!en) begin
      // Disable clears all status. period_out keeps its last value.
      state_d      = IDLE;
      cnt_d        = 32'd0;
      meas_valid_d = 1'b0;
      overrun_d    = 1'b0;
      count_d      = 10'd0;
    end else begin
      // An acknowledge retires the current measurement. A capture below in
      // the same cycle takes priority and leaves meas_valid set.
      if (meas_ack && meas_valid_q) begin
        meas_valid_d = 1'b0;
      end

      unique case (state_q)
        IDLE: begin
          // Rise events seen while idle are ignored.
          state_d = ARM;
        end

        ARM: begin
          if (rise) begin
            cnt_d   = 32'd0;
            state_d = MEASURE;
          end
        end

        MEASURE: begin
          if (rise) begin
            // A capture beats a timeout that falls in the same cycle.
            period_d     = cnt_sat_inc;
            cnt_d        = 32'd0;
            meas_valid_d = 1'b1;
            count_d      = count_q + 10'd1;
            if (meas_valid_q && !meas_ack) begin
              overrun_d = 1'b1;
            end
          end else if (timeout_hit) begin
            tmo_d   = 1'b1;
            cnt_d   = 32'd0;
            state_d = ARM;
          end else begin
            cnt_d = cnt_sat_inc;
          end
        end

        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      hist_q       <= 1'b0;
      cnt_q        <= 32'd0;
      period_q     <= 32'd0;
      meas_valid_q <= 1'b0;
      overrun_q    <= 1'b0;
      tmo_q        <= 1'b0;
      count_q      <= 10'd0;
    end else begin
      state_q      <= state_d;
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      hist_q       <= hist_d;
      cnt_q        <= cnt_d;
      period_q     <= period_d;
      meas_valid_q <= meas_valid_d;
      overrun_q    <= overrun_d;
      tmo_q        <= tmo_d;
      count_q      <= count_d;
    end
  end

  assign period_out = period_q;
  assign meas_valid = meas_valid_q;
  assign overrun    = overrun_q;
  assign tmo        = tmo_q;
  assign count      = count_q;

endmodule

// File: tb/tb_pulse_meter.sv
// ----------------------------------------------------------------------------
// tb_pulse_meter
//
// Directed testbench for pulse_meter. Inputs are driven and outputs sampled on
// the falling edge of clk. A pin raised just after falling edge n is acted on
// by the DUT before falling edge n+3.
// ----------------------------------------------------------------------------
module tb_pulse_meter;

  logic        clk;
  logic        rst;
  logic        en;
  logic        pulse_in;
  logic [31:0] timeout;
  logic        meas_ack;
  logic [31:0] period_out;
  logic        meas_valid;
  logic        overrun;
  logic        tmo;
  logic [9:0]  count;

  int tests;
  int fails;

  pulse_meter dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .pulse_in   (pulse_in),
    .timeout    (timeout),
    .meas_ack   (meas_ack),
    .period_out (period_out),
    .meas_valid (meas_valid),
    .overrun    (overrun),
    .tmo        (tmo),
    .count      (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // n rising edges spaced exactly 'period' cycles apart, starting now.
  task automatic gen_pulses(input int n, input int period);
    for (int i = 0; i < n; i++) begin
      pulse_in = 1'b1;
      tick(period / 2);
      pulse_in = 1'b0;
      tick(period - period / 2);
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    tests    = 0;
    fails    = 0;
    rst      = 1'b0;
    en       = 1'b0;
    pulse_in = 1'b0;
    timeout  = 32'd0;
    meas_ack = 1'b0;

    // Reset state
    tick(2);
    chk("rst_period", period_out, 32'd0);
    chk("rst_valid",  {31'd0, meas_valid}, 32'd0);
    chk("rst_overrun", {31'd0, overrun}, 32'd0);
    chk("rst_tmo",    {31'd0, tmo}, 32'd0);
    chk("rst_count",  {22'd0, count}, 32'd0);

    // Period 100, four edges: one arm plus three captures
    rst = 1'b1;
    en  = 1'b1;
    tick(2);
    gen_pulses(2, 100);
    chk("p100_count1",  {22'd0, count}, 32'd1);
    chk("p100_period1", period_out, 32'd100);
    chk("p100_valid1",  {31'd0, meas_valid}, 32'd1);
    chk("p100_ovr1",    {31'd0, overrun}, 32'd0);
    gen_pulses(2, 100);
    chk("p100_count3",  {22'd0, count}, 32'd3);
    chk("p100_period3", period_out, 32'd100);
    chk("p100_ovr3",    {31'd0, overrun}, 32'd1);

    // Disable clears status and keeps period_out
    en = 1'b0;
    tick(1);
    chk("dis_count",  {22'd0, count}, 32'd0);
    chk("dis_valid",  {31'd0, meas_valid}, 32'd0);
    chk("dis_ovr",    {31'd0, overrun}, 32'd0);
    chk("dis_period", period_out, 32'd100);

    // Timeout 50; next edge 80 cycles later only re-arms
    en      = 1'b1;
    timeout = 32'd50;
    tick(2);
    pulse_in = 1'b1;
    tick(1);
    pulse_in = 1'b0;
    tick(51);
    chk("tmo_before", {31'd0, tmo}, 32'd0);
    tick(1);
    chk("tmo_pulse",  {31'd0, tmo}, 32'd1);
    tick(1);
    chk("tmo_after",  {31'd0, tmo}, 32'd0);
    chk("tmo_count",  {22'd0, count}, 32'd0);
    chk("tmo_valid",  {31'd0, meas_valid}, 32'd0);
    tick(26);
    pulse_in = 1'b1;
    tick(1);
    pulse_in = 1'b0;
    tick(3);
    chk("rearm_count", {22'd0, count}, 32'd0);
    chk("rearm_valid", {31'd0, meas_valid}, 32'd0);
    tick(26);
    pulse_in = 1'b1;
    tick(1);
    pulse_in = 1'b0;
    tick(3);
    chk("after_tmo_count",  {22'd0, count}, 32'd1);
    chk("after_tmo_period", period_out, 32'd30);

    // Rise event coinciding with the timeout compare wins
    en = 1'b0;
    tick(1);
    en      = 1'b1;
    timeout = 32'd20;
    tick(2);
    gen_pulses(3, 20);
    chk("race_count",  {22'd0, count}, 32'd2);
    chk("race_period", period_out, 32'd20);
    timeout = 32'd0;

    // Period 20, never acknowledged: overrun on second capture
    en = 1'b0;
    tick(1);
    en = 1'b1;
    tick(2);
    gen_pulses(2, 20);
    chk("ovr_count1", {22'd0, count}, 32'd1);
    chk("ovr_flag1",  {31'd0, overrun}, 32'd0);
    gen_pulses(1, 20);
    chk("ovr_count2", {22'd0, count}, 32'd2);
    chk("ovr_flag2",  {31'd0, overrun}, 32'd1);
    chk("ovr_period", period_out, 32'd20);
    chk("ovr_valid",  {31'd0, meas_valid}, 32'd1);
    en = 1'b0;
    tick(1);
    chk("ovr_clr_flag",  {31'd0, overrun}, 32'd0);
    chk("ovr_clr_count", {22'd0, count}, 32'd0);

    // Acknowledge on the capture cycle, then on the following cycle
    en = 1'b1;
    tick(2);
    gen_pulses(2, 20);
    pulse_in = 1'b1;
    tick(1);
    pulse_in = 1'b0;
    tick(1);
    meas_ack = 1'b1;
    tick(1);
    meas_ack = 1'b0;
    chk("ack_cap_valid", {31'd0, meas_valid}, 32'd1);
    chk("ack_cap_ovr",   {31'd0, overrun}, 32'd0);
    chk("ack_cap_count", {22'd0, count}, 32'd2);
    meas_ack = 1'b1;
    tick(1);
    meas_ack = 1'b0;
    chk("ack_next_valid", {31'd0, meas_valid}, 32'd0);
    chk("ack_next_ovr",   {31'd0, overrun}, 32'd0);
    meas_ack = 1'b1;
    tick(1);
    meas_ack = 1'b0;
    chk("ack_idle_valid", {31'd0, meas_valid}, 32'd0);

    // 1025 captures at period 4: count wraps to 1
    en = 1'b0;
    tick(1);
    en = 1'b1;
    tick(2);
    gen_pulses(1026, 4);
    chk("wrap_count",  {22'd0, count}, 32'd1);
    chk("wrap_period", period_out, 32'd4);

    // Asynchronous reset mid-interval
    rst = 1'b0;
    #1;
    chk("arst_period", period_out, 32'd0);
    chk("arst_valid",  {31'd0, meas_valid}, 32'd0);
    chk("arst_ovr",    {31'd0, overrun}, 32'd0);
    chk("arst_tmo",    {31'd0, tmo}, 32'd0);
    chk("arst_count",  {22'd0, count}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    tick(2);
    gen_pulses(1, 10);
    chk("post_rst_arm_count", {22'd0, count}, 32'd0);
    chk("post_rst_arm_valid", {31'd0, meas_valid}, 32'd0);
    gen_pulses(1, 10);
    chk("post_rst_count",  {22'd0, count}, 32'd1);
    chk("post_rst_period", period_out, 32'd10);

    // Interval counter held at its ceiling: capture saturates
    force dut.cnt_q = 32'hFFFF_FFFF;
    pulse_in = 1'b1;
    tick(1);
    pulse_in = 1'b0;
    tick(2);
    chk("sat_period", period_out, 32'hFFFF_FFFF);
    chk("sat_count",  {22'd0, count}, 32'd2);
    release dut.cnt_q;
    tick(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
